aq_gemac_tx_framer: RTL and testbench

- GMII transmit framer in the tx_clk domain; drives the bgmii_txd/bgmii_txe/bgmii_txer inputs of the GMII I/O buffer stage.
- Takes a byte stream with valid/ready/last from the MAC TX FIFO.
- Emits preamble and SFD, then payload, then zero padding to the minimum frame size, then a 32-bit FCS, then the inter-frame gap.
- Detects FIFO underrun mid-frame and poisons the frame with TX error.

---
 rtl/aq_gemac_tx_framer.sv | 212 +++++++++++++++++++++
 tb/tb_aq_gemac_tx_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_gemac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : aq_gemac_tx_framer
// Purpose  : GMII TX framer - preamble/SFD, payload, pad, FCS, IFG, underrun
// Revision : 1.0
// ============================================================================
module aq_gemac_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] bgmii_txd,
  output logic       bgmii_txe,
  output logic       bgmii_txer,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SFD   = 3'd2,
    S_DATA  = 3'd3,
    S_PAD   = 3'd4,
    S_FCS   = 3'd5,
    S_DRAIN = 3'd6,
    S_IFG   = 3'd7
  } state_t;

  localparam logic [3:0]  c_pre_last  = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  c_ifg_last  = 8'(IFG_BYTES - 1);
  localparam logic [10:0] c_min_frame = 11'(MIN_FRAME);
  localparam logic [10:0] c_cnt_max   = 11'h7FF;
  localparam logic [31:0] c_crc_init  = 32'hFFFF_FFFF;
  localparam logic [31:0] c_crc_poly  = 32'hEDB8_8320;

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  fcs_cnt_q, fcs_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        abort_q, abort_d;
  logic [7:0]  txd_q, txd_d;
  logic        txe_q, txe_d;
  logic        txer_q, txer_d;
  logic        done_q, done_d;
  logic        undr_q, undr_d;
  logic        ready_q;
  logic        busy_q;

  logic [10:0] w_byte_inc;
  logic [31:0] w_fcs;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ c_crc_poly) : (r >> 1);
    end
    return r;
  endfunction

  assign w_byte_inc = (byte_cnt_q == c_cnt_max) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign w_fcs      = ~crc_q;

  // Output registers carry what the current state drives, so the wire lags
  // the state by one cycle and an accepted byte appears the cycle after.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    fcs_cnt_d  = fcs_cnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    abort_d    = abort_q;
    txd_d      = 8'h00;
    txe_d      = 1'b0;
    txer_d     = 1'b0;
    done_d     = 1'b0;
    undr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        txd_d = 8'h55;
        txe_d = 1'b1;
        if (pre_cnt_q == c_pre_last) begin
          state_d = S_SFD;
        end else begin
          pre_cnt_d = pre_cnt_q + 4'd1;
        end
      end
      S_SFD: begin
        txd_d      = 8'hD5;
        txe_d      = 1'b1;
        crc_d      = c_crc_init;
        pre_cnt_d  = 4'd0;
        fcs_cnt_d  = 2'd0;
        ifg_cnt_d  = 8'd0;
        byte_cnt_d = 11'd0;
        abort_d    = 1'b0;
        state_d    = S_DATA;
      end
      S_DATA: begin
        txe_d = 1'b1;
        if (tx_valid) begin
          txd_d      = tx_data;
          crc_d      = crc32_byte(crc_q, tx_data);
          byte_cnt_d = w_byte_inc;
          if (tx_last) begin
            state_d = (w_byte_inc < c_min_frame) ? S_PAD : S_FCS;
          end
        end else begin
          txer_d  = 1'b1;
          undr_d  = 1'b1;
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_PAD: begin
        txe_d      = 1'b1;
        crc_d      = crc32_byte(crc_q, 8'h00);
        byte_cnt_d = w_byte_inc;
        if (w_byte_inc >= c_min_frame) begin
          state_d = S_FCS;
        end
      end
      S_FCS: begin
        txe_d     = 1'b1;
        txd_d     = w_fcs[{fcs_cnt_q, 3'b000} +: 8];
        fcs_cnt_d = fcs_cnt_q + 2'd1;
        if (fcs_cnt_q == 2'd3) begin
          state_d = S_IFG;
        end
      end
      S_DRAIN: begin
        if (tx_valid && tx_last) begin
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        done_d = (ifg_cnt_q == 8'd0) && !abort_q;
        if (ifg_cnt_q == c_ifg_last) begin
          // Going straight to PRE keeps the wire gap at exactly IFG_BYTES.
          state_d = tx_valid ? S_PRE : S_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= 4'd0;
      fcs_cnt_q  <= 2'd0;
      ifg_cnt_q  <= 8'd0;
      byte_cnt_q <= 11'd0;
      crc_q      <= c_crc_init;
      abort_q    <= 1'b0;
      txd_q      <= 8'h00;
      txe_q      <= 1'b0;
      txer_q     <= 1'b0;
      done_q     <= 1'b0;
      undr_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      fcs_cnt_q  <= fcs_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      abort_q    <= abort_d;
      txd_q      <= txd_d;
      txe_q      <= txe_d;
      txer_q     <= txer_d;
      done_q     <= done_d;
      undr_q     <= undr_d;
      ready_q    <= (state_d == S_DATA) || (state_d == S_DRAIN);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign tx_ready    = ready_q;
  assign bgmii_txd   = txd_q;
  assign bgmii_txe   = txe_q;
  assign bgmii_txer  = txer_q;
  assign tx_done     = done_q;
  assign tx_underrun = undr_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aq_gemac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_gemac_tx_framer
// Purpose  : scoreboard bench for aq_gemac_tx_framer (default and MIN_FRAME=0)
// Revision : 1.0
// ============================================================================
module tb_aq_gemac_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #4 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic       tx_ready, txe, txer, done, undr, busy;
  logic [7:0] txd;

  logic [7:0] tx_data0 = 8'h00;
  logic       tx_valid0 = 1'b0, tx_last0 = 1'b0;
  logic       rdy0, txe0, txer0, done0, undr0, busy0;
  logic [7:0] txd0;

  aq_gemac_tx_framer dut (
    .tx_clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .bgmii_txd(txd), .bgmii_txe(txe), .bgmii_txer(txer),
    .tx_done(done), .tx_underrun(undr), .busy(busy)
  );

  aq_gemac_tx_framer #(.MIN_FRAME(0)) dut0 (
    .tx_clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_last(tx_last0),
    .tx_ready(rdy0), .bgmii_txd(txd0), .bgmii_txe(txe0), .bgmii_txer(txer0),
    .tx_done(done0), .tx_underrun(undr0), .busy(busy0)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp0_q[$];

  int run_cur = 0, last_run = 0, gap_cur = 0, last_gap = 0;
  int done_cnt = 0, undr_cnt = 0, ready_cnt = 0;
  bit prev_txe = 1'b0;
  int run0_cur = 0, run0_last = 0, gap0_cur = 0, done0_cnt = 0;
  bit prev0 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] pl[$], input int min_len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 7; k++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    foreach (pl[i]) begin
      exp_q.push_back({1'b0, pl[i]});
      c = crc_upd(c, pl[i]);
    end
    for (int n = pl.size(); n < min_len; n++) begin
      exp_q.push_back(9'h000);
      c = crc_upd(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
  endtask

  // Drive one byte and hold it until a negedge shows tx_ready, then let the edge take it.
  task automatic put(input bit s, input logic [7:0] b, input bit l);
    int n;
    n = 0;
    if (s) begin tx_valid0 = 1'b1; tx_data0 = b; tx_last0 = l; end
    else   begin tx_valid  = 1'b1; tx_data  = b; tx_last  = l; end
    do begin
      @(negedge clk);
      n++;
    end while (!(s ? rdy0 : tx_ready) && n < 500);
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL put_timeout: tx_ready got 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit s, input logic [7:0] pl[$], input int cut, input bit hold);
    foreach (pl[i]) begin
      put(s, pl[i], (i == pl.size() - 1));
      if (i == cut) begin
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    if (!hold) begin
      if (s) begin tx_valid0 = 1'b0; tx_last0 = 1'b0; end
      else   begin tx_valid  = 1'b0; tx_last  = 1'b0; end
    end
  endtask

  task automatic wait_idle(input bit s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((s ? busy0 : busy) && n < 3000);
    #1;
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy got 1 after %0d cycles, expected 0", n);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (txe) begin
      if (!prev_txe) begin last_gap = gap_cur; run_cur = 1; end
      else run_cur++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wire_byte: got txd=%02h txer=%0b, expected no transmission", txd, txer);
      end else begin
        e = exp_q.pop_front();
        chk("wire_byte", 32'({txer, txd}), 32'(e));
      end
    end else begin
      if (prev_txe) begin last_run = run_cur; gap_cur = 1; end
      else gap_cur++;
    end
    if (done)     done_cnt++;
    if (undr)     undr_cnt++;
    if (tx_ready) ready_cnt++;
    prev_txe = txe;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (txe0) begin
      run0_cur = prev0 ? run0_cur + 1 : 1;
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wire_byte0: got txd=%02h txer=%0b, expected no transmission", txd0, txer0);
      end else begin
        e = exp0_q.pop_front();
        chk("wire_byte0", 32'({txer0, txd0}), 32'(e));
      end
    end else begin
      if (prev0) begin run0_last = run0_cur; gap0_cur = 1; end
      else gap0_cur++;
    end
    if (done0) done0_cnt++;
    prev0 = txe0;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] ply[$];
    int d0, u0, r0;

    // Reset held with a request pending.
    rst = 1'b1;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({txd, txe, txer, tx_ready, done, undr, busy}), 32'h0);
    for (int k = 0; k < 3; k++) exp_q.push_back(9'h055);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("busy_before_pre", 32'(busy), 32'h0);
    @(negedge clk); chk("busy_in_pre", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_pre_outputs", 32'({txd, txe, txer, tx_ready, done, undr, busy}), 32'h0);
    chk("pre_bytes_before_reset", 32'(exp_q.size()), 32'h0);

    // 1-byte payload, padded to 60.
    pl.delete();
    pl.push_back(8'hAB);
    push_frame(pl, 60);
    d0 = done_cnt; u0 = undr_cnt;
    @(posedge clk); #1 rst = 1'b0;
    send(1'b0, pl, -1, 1'b0);
    wait_idle(1'b0);
    chk("ab_done", 32'(done_cnt - d0), 32'd1);
    chk("ab_txe_len", 32'(last_run), 32'd72);
    chk("ab_no_underrun", 32'(undr_cnt - u0), 32'd0);

    // 64-byte payload, no padding.
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i * 5 + 3));
    push_frame(pl, 60);
    d0 = done_cnt; r0 = ready_cnt;
    send(1'b0, pl, -1, 1'b0);
    wait_idle(1'b0);
    chk("p64_ready_cycles", 32'(ready_cnt - r0), 32'd64);
    chk("p64_txe_len", 32'(last_run), 32'd76);
    chk("p64_done", 32'(done_cnt - d0), 32'd1);

    // Underrun after byte 10 of a 100-byte frame.
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(8'(i) ^ 8'h5A);
    for (int k = 0; k < 7; k++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, pl[i]});
    exp_q.push_back(9'h100);
    d0 = done_cnt; u0 = undr_cnt;
    send(1'b0, pl, 9, 1'b0);
    wait_idle(1'b0);
    chk("ur_pulse", 32'(undr_cnt - u0), 32'd1);
    chk("ur_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ur_txe_len", 32'(last_run), 32'd19);

    // Back-to-back frames with tx_valid held across the gap.
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'hC0 + 8'(i));
    ply.delete();
    for (int i = 0; i < 3; i++) ply.push_back(8'h10 + 8'(i));
    push_frame(pl, 60);
    push_frame(ply, 60);
    d0 = done_cnt;
    send(1'b0, pl, -1, 1'b1);
    send(1'b0, ply, -1, 1'b0);
    wait_idle(1'b0);
    chk("b2b_gap", 32'(last_gap), 32'd12);
    chk("b2b_txe_len", 32'(last_run), 32'd72);
    chk("b2b_done", 32'(done_cnt - d0), 32'd2);

    // MIN_FRAME=0 instance: "123456789" with the well-known CRC check value.
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    for (int k = 0; k < 7; k++) exp0_q.push_back(9'h055);
    exp0_q.push_back(9'h0D5);
    foreach (pl[i]) exp0_q.push_back({1'b0, pl[i]});
    exp0_q.push_back(9'h026);
    exp0_q.push_back(9'h039);
    exp0_q.push_back(9'h0F4);
    exp0_q.push_back(9'h0CB);
    send(1'b1, pl, -1, 1'b0);
    wait_idle(1'b1);
    chk("crc_done", 32'(done0_cnt), 32'd1);
    chk("crc_txe_len", 32'(run0_last), 32'd21);
    chk("crc_ifg_len", 32'(gap0_cur), 32'd12);

    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    chk("leftover_expected0", 32'(exp0_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
